cofre_ctrl: RTL and testbench
=============================

COFRE_CTRL -- requirements
Module: cofre_ctrl

Interface
REQ-001 SHALL have parameter N_DIG, default 6, digits per code entry.
REQ-002 SHALL have parameter MAX_ERROS, default 3, wrong entries before lockout.
REQ-003 SHALL have parameter T_BLOQ, default 16, lockout duration in clk cycles.
REQ-004 SHALL have parameter T_ABERTO, default 8, open-window duration in clk cycles.
REQ-005 clk  input  1  single system clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 insere  input  1  digit-entry key, level; one digit per 0->1 transition.
REQ-008 numero  input  4  BCD digit presented with insere.
REQ-009 programa  input  1  request to reprogram code, honoured only in ABERTO.
REQ-010 aberto  output  1  lock open, registered.
REQ-011 bloqueado  output  1  lockout active, registered.
REQ-012 erro  output  1  one-cycle pulse on wrong entry or rejected digit.
REQ-013 indice  output  3  count of digits accepted in current entry/programming pass.
REQ-014 tentativas  output  2  wrong entries since last success or lockout end.

Function
REQ-015 SHALL accept a digit only in the cycle where insere=1 and insere was 0 in the previous cycle; holding insere high SHALL yield exactly one digit.
REQ-016 SHALL hold a code register of N_DIG 4-bit digits, reset value 5,9,0,9,8,1 (index 0 first).
REQ-017 SHALL implement states OCIOSO, ENTRADA, ABERTO, PROGRAMA, BLOQUEIO; reset state OCIOSO.
REQ-018 OCIOSO: accepted digit -> ENTRADA, indice=1, compared against code[0].
REQ-019 ENTRADA: each accepted digit SHALL be compared to code[indice]; any mismatch, or numero>9, SHALL set a sticky mismatch flag without changing state early.
REQ-020 On the N_DIG-th accepted digit, next cycle: no mismatch -> ABERTO, aberto=1, tentativas=0; mismatch -> erro=1 for one cycle, tentativas+1, OCIOSO; indice=0 in both cases.
REQ-021 When tentativas would reach MAX_ERROS, next state SHALL be BLOQUEIO instead of OCIOSO, bloqueado=1, erro still pulses.
REQ-022 BLOQUEIO: insere SHALL be ignored; after exactly T_BLOQ cycles -> OCIOSO, bloqueado=0, tentativas=0.
REQ-023 ABERTO: aberto=1 for T_ABERTO cycles then -> OCIOSO; programa=1 in any ABERTO cycle -> PROGRAMA (aberto stays 1).
REQ-024 PROGRAMA: each accepted digit <=9 SHALL be written to code[indice], indice+1; numero>9 SHALL pulse erro and not advance indice.
REQ-025 After the N_DIG-th write -> OCIOSO, aberto=0, indice=0; new code effective for the next entry.
REQ-026 Digits accepted in ABERTO while programa=0 SHALL be ignored.
REQ-027 tentativas SHALL saturate, never wrap; timers SHALL be sized by $clog2 of their parameter.

Reset
REQ-028 On reset low: state OCIOSO, aberto=0, bloqueado=0, erro=0, indice=0, tentativas=0, timers 0, code register to reset value, insere history 0.
REQ-029 Reset mid-entry, mid-programming or mid-lockout SHALL abandon the operation; a partially programmed code SHALL revert to the reset value.

Structure
REQ-030 Shared package cofre_pkg SHALL hold the state enumeration, the reset code constant and the digit width.
REQ-031 Rising-edge detection of insere SHALL be a sub-module pulso_borda (1-bit, clk/reset).

Verification
REQ-032 Enter 5,9,0,9,8,1 with separate insere pulses -> aberto=1 the cycle after the 6th edge, held 8 cycles, tentativas=0.
REQ-033 Enter 5,9,0,9,8,2 -> no aberto, erro one cycle after 6th digit, tentativas=1; early mismatch at digit 1 still requires all 6 digits.
REQ-034 Three wrong entries -> bloqueado=1 after third; insere pulses during 16 cycles ignored; then bloqueado=0, tentativas=0, correct code opens.
REQ-035 Open, assert programa, enter 1,2,3,4,5,6 plus one 4'hA -> erro pulse on 4'hA only; old code rejected, 1,2,3,4,5,6 opens.
REQ-036 insere held high 10 cycles with numero=5 -> indice=1 only.
REQ-037 Reset low after 3 digits programmed -> all outputs 0, code 5,9,0,9,8,1 opens.

Source files
------------

// File: rtl/cofre_pkg.sv
// Shared definitions for the code-lock controller.
//   estado_t      : controller state enumeration
//   DIG_W         : width of one BCD digit
//   N_RESET       : number of digits in the power-up code
//   CODIGO_RESET  : power-up code, digit 0 in the least significant nibble
//   codigo_reset_dig(i) : power-up value of digit i (0 beyond N_RESET)
package cofre_pkg;

  localparam int DIG_W   = 4;
  localparam int N_RESET = 6;

  // 5,9,0,9,8,1 with index 0 first (lowest nibble)
  localparam logic [N_RESET*DIG_W-1:0] CODIGO_RESET =
    {4'd1, 4'd8, 4'd9, 4'd0, 4'd9, 4'd5};

  typedef enum logic [2:0] {
    OCIOSO,
    ENTRADA,
    ABERTO,
    PROGRAMA,
    BLOQUEIO
  } estado_t;

  function automatic logic [DIG_W-1:0] codigo_reset_dig(input int i);
    if (i < N_RESET) return CODIGO_RESET[i*DIG_W +: DIG_W];
    return '0;
  endfunction

endpackage

// File: rtl/pulso_borda.sv
// Rising-edge detector for a level input.
//   clk   : system clock
//   reset : asynchronous active-low reset (history cleared to 0)
//   sinal : level input
//   borda : high in the cycle where sinal=1 and sinal was 0 the cycle before
module pulso_borda (
  input  logic clk,
  input  logic reset,
  input  logic sinal,
  output logic borda
);

  logic sinal_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sinal_q <= 1'b0;
    else        sinal_q <= sinal;
  end

  assign borda = sinal & ~sinal_q;

endmodule

// File: rtl/cofre_ctrl.sv
// Digital code lock controller.
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   insere     : digit key (level); one digit per rising transition
//   numero     : BCD digit presented with insere
//   programa   : request code reprogramming while open
//   aberto     : lock open (registered)
//   bloqueado  : lockout active (registered)
//   erro       : one-cycle pulse on wrong entry or rejected digit
//   indice     : digits accepted in the current entry/programming pass
//   tentativas : wrong entries since last success or lockout end (saturating)
//
// state    | meaning
// OCIOSO   | idle, waiting for first digit
// ENTRADA  | collecting digits, mismatch remembered until the last one
// ABERTO   | open window, programa moves to PROGRAMA
// PROGRAMA | writing a new code digit by digit, lock stays open
// BLOQUEIO | lockout, key ignored until timer expires
module cofre_ctrl
  import cofre_pkg::*;
#(
  parameter int N_DIG     = 6,
  parameter int MAX_ERROS = 3,
  parameter int T_BLOQ    = 16,
  parameter int T_ABERTO  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       insere,
  input  logic [3:0] numero,
  input  logic       programa,
  output logic       aberto,
  output logic       bloqueado,
  output logic       erro,
  output logic [2:0] indice,
  output logic [1:0] tentativas
);

  localparam int TA_W = (T_ABERTO > 1) ? $clog2(T_ABERTO) : 1;
  localparam int TB_W = (T_BLOQ > 1) ? $clog2(T_BLOQ) : 1;
  localparam logic [TA_W-1:0] TA_INI = TA_W'(T_ABERTO - 1);
  localparam logic [TB_W-1:0] TB_INI = TB_W'(T_BLOQ - 1);
  localparam logic [2:0] ULTIMO = 3'(N_DIG - 1);
  localparam logic [2:0] MAX_E  = 3'(MAX_ERROS);

  estado_t estado_q, estado_d;
  logic [N_DIG-1:0][DIG_W-1:0] code_q, code_d;
  logic [TA_W-1:0] timer_a_q, timer_a_d;
  logic [TB_W-1:0] timer_b_q, timer_b_d;
  logic mismatch_q, mismatch_d;
  logic aberto_d, bloqueado_d, erro_d;
  logic [2:0] indice_d;
  logic [1:0] tent_d, tent_inc;
  logic digito, erra, trava;

  pulso_borda u_borda (
    .clk   (clk),
    .reset (reset),
    .sinal (insere),
    .borda (digito)
  );

  assign tent_inc = (tentativas == 2'd3) ? 2'd3 : tentativas + 2'd1;
  assign trava    = ({1'b0, tentativas} + 3'd1) >= MAX_E;
  // Mismatch of the current digit, folded with what was seen earlier in this entry
  assign erra = ((estado_q == ENTRADA) && mismatch_q) || (numero > 4'd9) ||
                (numero != code_q[indice]);

  always_comb begin
    estado_d     = estado_q;
    code_d       = code_q;
    timer_a_d    = timer_a_q;
    timer_b_d    = timer_b_q;
    mismatch_d   = mismatch_q;
    aberto_d     = aberto;
    bloqueado_d  = bloqueado;
    erro_d       = 1'b0;
    indice_d     = indice;
    tent_d       = tentativas;
    case (estado_q)
      OCIOSO, ENTRADA: begin
        if (digito) begin
          if (indice == ULTIMO) begin
            indice_d   = 3'd0;
            mismatch_d = 1'b0;
            if (!erra) begin
              estado_d  = ABERTO;
              aberto_d  = 1'b1;
              tent_d    = 2'd0;
              timer_a_d = TA_INI;
            end else begin
              erro_d = 1'b1;
              tent_d = tent_inc;
              if (trava) begin
                estado_d    = BLOQUEIO;
                bloqueado_d = 1'b1;
                timer_b_d   = TB_INI;
              end else begin
                estado_d = OCIOSO;
              end
            end
          end else begin
            indice_d   = indice + 3'd1;
            mismatch_d = erra;
            estado_d   = ENTRADA;
          end
        end
      end
      ABERTO: begin
        // programa wins over window expiry; digits here are ignored
        if (programa) begin
          estado_d = PROGRAMA;
          indice_d = 3'd0;
        end else if (timer_a_q == '0) begin
          estado_d = OCIOSO;
          aberto_d = 1'b0;
        end else begin
          timer_a_d = timer_a_q - TA_W'(1);
        end
      end
      PROGRAMA: begin
        if (digito) begin
          if (numero > 4'd9) begin
            erro_d = 1'b1;
          end else begin
            code_d[indice] = numero;
            if (indice == ULTIMO) begin
              estado_d = OCIOSO;
              aberto_d = 1'b0;
              indice_d = 3'd0;
            end else begin
              indice_d = indice + 3'd1;
            end
          end
        end
      end
      BLOQUEIO: begin
        if (timer_b_q == '0) begin
          estado_d    = OCIOSO;
          bloqueado_d = 1'b0;
          tent_d      = 2'd0;
        end else begin
          timer_b_d = timer_b_q - TB_W'(1);
        end
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q   <= OCIOSO;
      for (int i = 0; i < N_DIG; i++) code_q[i] <= codigo_reset_dig(i);
      timer_a_q  <= '0;
      timer_b_q  <= '0;
      mismatch_q <= 1'b0;
      aberto     <= 1'b0;
      bloqueado  <= 1'b0;
      erro       <= 1'b0;
      indice     <= 3'd0;
      tentativas <= 2'd0;
    end else begin
      estado_q   <= estado_d;
      code_q     <= code_d;
      timer_a_q  <= timer_a_d;
      timer_b_q  <= timer_b_d;
      mismatch_q <= mismatch_d;
      aberto     <= aberto_d;
      bloqueado  <= bloqueado_d;
      erro       <= erro_d;
      indice     <= indice_d;
      tentativas <= tent_d;
    end
  end

endmodule

// File: tb/tb_cofre_ctrl.sv
module tb_cofre_ctrl;

  typedef logic [3:0] cod_t [6];

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic insere = 1'b0;
  logic programa = 1'b0;
  logic [3:0] numero = 4'd0;
  logic aberto, bloqueado, erro;
  logic [2:0] indice;
  logic [1:0] tentativas;

  localparam int T_ABERTO = 8;
  localparam int T_BLOQ   = 16;
  localparam cod_t COD_RESET = '{4'd5, 4'd9, 4'd0, 4'd9, 4'd8, 4'd1};

  cod_t ref_code;
  int tent_m;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cofre_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .insere     (insere),
    .numero     (numero),
    .programa   (programa),
    .aberto     (aberto),
    .bloqueado  (bloqueado),
    .erro       (erro),
    .indice     (indice),
    .tentativas (tentativas)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic press(input logic [3:0] d);
    numero = d;
    insere = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic soltar(input int n);
    insere = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Enters a 6-digit code; returns whether the model expects it to open.
  task automatic enter(input cod_t c, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      press(c[i]);
      if (c[i] !== ref_code[i]) ok = 1'b0;
      if (i < 5) begin
        total++;
        if (indice !== 3'(i + 1)) begin
          bad++; $display("FAIL entry_indice got=%0d exp=%0d", indice, i + 1);
        end
        total++;
        if (erro !== 1'b0) begin
          bad++; $display("FAIL early_erro got=%0b exp=0", erro);
        end
        soltar($urandom_range(1, 3));
      end
    end
  endtask

  // Checks the outcome right after the last digit edge.
  task automatic finish_entry(input bit ok, input bit stay_open);
    int n;
    total++;
    if (indice !== 3'd0) begin
      bad++; $display("FAIL end_indice got=%0d exp=0", indice);
    end
    if (ok) begin
      tent_m = 0;
      total++;
      if (aberto !== 1'b1) begin bad++; $display("FAIL open got=%0b exp=1", aberto); end
      total++;
      if (tentativas !== 2'd0) begin
        bad++; $display("FAIL open_tent got=%0d exp=0", tentativas);
      end
      total++;
      if (erro !== 1'b0) begin bad++; $display("FAIL open_erro got=%0b exp=0", erro); end
      if (!stay_open) begin
        insere = 1'b0;
        n = 0;
        while (aberto === 1'b1 && n < 40) begin
          n++; @(posedge clk); #1;
        end
        total++;
        if (n != T_ABERTO) begin bad++; $display("FAIL open_window got=%0d exp=%0d", n, T_ABERTO); end
      end
    end else begin
      tent_m = (tent_m < 3) ? tent_m + 1 : 3;
      total++;
      if (erro !== 1'b1) begin bad++; $display("FAIL wrong_erro got=%0b exp=1", erro); end
      total++;
      if (aberto !== 1'b0) begin bad++; $display("FAIL wrong_aberto got=%0b exp=0", aberto); end
      total++;
      if (tentativas !== 2'(tent_m)) begin
        bad++; $display("FAIL wrong_tent got=%0d exp=%0d", tentativas, tent_m);
      end
      if (tent_m >= 3) begin
        total++;
        if (bloqueado !== 1'b1) begin bad++; $display("FAIL lock got=%0b exp=1", bloqueado); end
        n = 0;
        while (bloqueado === 1'b1 && n < 40) begin
          insere = 1'($urandom_range(0, 1));
          numero = 4'($urandom_range(0, 15));
          n++; @(posedge clk); #1;
        end
        insere = 1'b0;
        total++;
        if (n != T_BLOQ) begin bad++; $display("FAIL lock_len got=%0d exp=%0d", n, T_BLOQ); end
        total++;
        if (tentativas !== 2'd0) begin
          bad++; $display("FAIL lock_tent got=%0d exp=0", tentativas);
        end
        total++;
        if (indice !== 3'd0) begin bad++; $display("FAIL lock_indice got=%0d exp=0", indice); end
        tent_m = 0;
        soltar(1);
      end else begin
        total++;
        if (bloqueado !== 1'b0) begin bad++; $display("FAIL nolock got=%0b exp=0", bloqueado); end
        soltar(1);
        total++;
        if (erro !== 1'b0) begin bad++; $display("FAIL erro_pulse got=%0b exp=0", erro); end
      end
    end
  endtask

  // Called while open; writes new code, optional 4'hA injected before digit bad_pos.
  task automatic programar(input cod_t nc, input int bad_pos);
    insere = 1'b0;
    programa = 1'b1;
    @(posedge clk); #1;
    programa = 1'b0;
    total++;
    if (aberto !== 1'b1) begin bad++; $display("FAIL prog_aberto got=%0b exp=1", aberto); end
    for (int i = 0; i < 6; i++) begin
      if (i == bad_pos) begin
        press(4'hA);
        total++;
        if (erro !== 1'b1) begin bad++; $display("FAIL prog_bad_erro got=%0b exp=1", erro); end
        total++;
        if (indice !== 3'(i)) begin
          bad++; $display("FAIL prog_bad_indice got=%0d exp=%0d", indice, i);
        end
        soltar(1);
      end
      press(nc[i]);
      total++;
      if (erro !== 1'b0) begin bad++; $display("FAIL prog_erro got=%0b exp=0", erro); end
      if (i < 5) begin
        total++;
        if (indice !== 3'(i + 1)) begin
          bad++; $display("FAIL prog_indice got=%0d exp=%0d", indice, i + 1);
        end
        total++;
        if (aberto !== 1'b1) begin bad++; $display("FAIL prog_open got=%0b exp=1", aberto); end
        soltar(1);
      end else begin
        total++;
        if (indice !== 3'd0) begin bad++; $display("FAIL prog_end_indice got=%0d exp=0", indice); end
        total++;
        if (aberto !== 1'b0) begin bad++; $display("FAIL prog_end_aberto got=%0b exp=0", aberto); end
      end
    end
    ref_code = nc;
    soltar(1);
  endtask

  task automatic check_zero(input string nm);
    total++;
    if ({aberto, bloqueado, erro, indice, tentativas} !== 8'd0) begin
      bad++;
      $display("FAIL %s got=%b%b%b/%0d/%0d exp=all zero", nm, aberto, bloqueado, erro, indice, tentativas);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; insere = 1'b0; programa = 1'b0;
    repeat (2) @(posedge clk); #1;
    check_zero("reset_state");
    reset = 1'b1;
    @(posedge clk); #1;
    ref_code = COD_RESET;
    tent_m = 0;
  endtask

  task automatic test_open;
    bit ok;
    enter(COD_RESET, ok);
    finish_entry(ok, 1'b0);
  endtask

  task automatic test_wrong;
    bit ok;
    cod_t c;
    c = '{4'd5, 4'd9, 4'd0, 4'd9, 4'd8, 4'd2};
    enter(c, ok);
    finish_entry(ok, 1'b0);
    c = '{4'd3, 4'd9, 4'd0, 4'd9, 4'd8, 4'd1};
    enter(c, ok);
    finish_entry(ok, 1'b0);
  endtask

  task automatic test_lockout;
    bit ok;
    cod_t c;
    c = '{4'd5, 4'd9, 4'd0, 4'd9, 4'd8, 4'd7};
    enter(c, ok);
    finish_entry(ok, 1'b0);
    enter(COD_RESET, ok);
    finish_entry(ok, 1'b0);
  endtask

  task automatic test_program;
    bit ok;
    cod_t nc;
    nc = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    enter(ref_code, ok);
    finish_entry(ok, 1'b1);
    programar(nc, 3);
    enter(COD_RESET, ok);
    finish_entry(ok, 1'b0);
    enter(nc, ok);
    finish_entry(ok, 1'b0);
  endtask

  task automatic test_hold;
    bit ok;
    numero = 4'd5;
    insere = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (indice !== 3'd1) begin bad++; $display("FAIL hold_indice got=%0d exp=1", indice); end
    ok = (ref_code[0] == 4'd5);
    soltar(1);
    for (int i = 1; i < 6; i++) begin
      press(ref_code[i]);
      if (i < 5) soltar(1);
    end
    finish_entry(ok, 1'b0);
  endtask

  task automatic test_reset_prog;
    bit ok;
    enter(ref_code, ok);
    finish_entry(ok, 1'b1);
    insere = 1'b0;
    programa = 1'b1;
    @(posedge clk); #1;
    programa = 1'b0;
    for (int i = 0; i < 3; i++) begin
      press(4'd7);
      soltar(1);
    end
    reset = 1'b0;
    #1;
    check_zero("reset_midprog");
    @(posedge clk); #1;
    reset = 1'b1;
    ref_code = COD_RESET;
    tent_m = 0;
    @(posedge clk); #1;
    enter(COD_RESET, ok);
    finish_entry(ok, 1'b0);
  endtask

  task automatic test_random;
    bit ok;
    cod_t c;
    cod_t nc;
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 3) < 2) c = ref_code;
      else for (int i = 0; i < 6; i++) c[i] = 4'($urandom_range(0, 15));
      enter(c, ok);
      if (ok && $urandom_range(0, 2) == 0) begin
        finish_entry(ok, 1'b1);
        for (int i = 0; i < 6; i++) nc[i] = 4'($urandom_range(0, 9));
        programar(nc, $urandom_range(0, 6));
      end else begin
        finish_entry(ok, 1'b0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_open();
    test_wrong();
    test_lockout();
    test_program();
    test_hold();
    test_reset_prog();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
